// File: rtl/flappy_pkg.sv
// flappy_pkg: types and constants shared by the pipe scheduler and its gap
// legalizer.
//   ROWS / COLS  : playfield size
//   state_e      : scheduler FSM states
//   pipe_slot_t  : one entry of the pipe table
//   solid_mask() : wall rows for a legal gap (1 = solid row)
package flappy_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] x;
    logic [2:0] top;
    logic [3:0] sz;
  } pipe_slot_t;

  // Rows top..top+sz-1 are open; every other row is wall. The bounds are
  // 4 bits wide so top+sz (at most 14) cannot wrap.
  function automatic logic [ROWS-1:0] solid_mask(input logic [2:0] top,
                                                 input logic [3:0] sz);
    logic [ROWS-1:0] mask;
    logic [3:0]      lo;
    logic [3:0]      hi;
    lo = {1'b0, top};
    hi = lo + sz;
    for (int r = 0; r < ROWS; r++) begin
      mask[r] = !((4'(r) >= lo) && (4'(r) < hi));
    end
    return mask;
  endfunction

endpackage

// File: rtl/pipe_scheduler_gap_legalize.sv
// gap_legalize: turns the raw gap generator outputs into a gap that fits the
// playfield: the size is raised to MIN_GAP, and the gap is pushed up when it
// would run past the last row. Purely combinational.
//   gap_height : raw gap top row
//   gap_size   : raw gap size
//   top, sz    : legalized gap
//   mask       : wall rows of the legalized gap (1 = solid)
module gap_legalize
  import flappy_pkg::*;
#(
  parameter int MIN_GAP = 2
) (
  input  logic [2:0] gap_height,
  input  logic [2:0] gap_size,
  output logic [2:0] top,
  output logic [3:0] sz,
  output logic [7:0] mask
);

  localparam logic [3:0] MIN_SZ = 4'(MIN_GAP);

  logic [3:0] w_sz;
  logic [3:0] w_end;
  logic [2:0] w_top;

  always_comb begin
    w_sz  = ({1'b0, gap_size} < MIN_SZ) ? MIN_SZ : {1'b0, gap_size};
    w_end = {1'b0, gap_height} + w_sz;
    w_top = (w_end > 4'd8) ? 3'(4'd8 - w_sz) : gap_height;
  end

  assign top  = w_top;
  assign sz   = w_sz;
  assign mask = solid_mask(w_top, w_sz);

endmodule

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: keeps a small table of scrolling pipes. Each RUN tick moves
// every pipe one column left, retires pipes leaving column 0, and every
// SPACING ticks spawns a new pipe at the right edge using the gap generator's
// current outputs.
//   clock, reset     : rising-edge clock, synchronous active-low reset
//   enable           : run request (low pauses)
//   clear            : flush the table and return to IDLE
//   tick             : one-cycle scroll strobe
//   gap_height/size  : raw gap from the gap generator, used at spawn only
//   rd_col/rd_pixels : combinational wall lookup for the display scan
//   pipe_count       : number of valid slots
//   score_pulse      : a pipe passed the bird column
//   spawn_drop       : a spawn was lost because the table was full
//   state            : FSM state (IDLE=0, RUN=1, PAUSE=2)
module pipe_scheduler #(
  parameter int COLS     = flappy_pkg::COLS,
  parameter int SLOTS    = 4,
  parameter int SPACING  = 5,
  parameter int BIRD_COL = 2,
  parameter int MIN_GAP  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic       tick,
  input  logic [2:0] gap_height,
  input  logic [2:0] gap_size,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_pixels,
  output logic [2:0] pipe_count,
  output logic       score_pulse,
  output logic       spawn_drop,
  output logic [1:0] state
);

  import flappy_pkg::*;

  localparam logic [3:0] LAST_X       = 4'(COLS - 1);
  localparam logic [3:0] BIRD_X       = 4'(BIRD_COL);
  localparam logic [3:0] SPAWN_RELOAD = 4'(SPACING - 1);

  state_e     r_state, w_state_nxt;
  pipe_slot_t r_slots     [SLOTS];
  pipe_slot_t w_slots_nxt [SLOTS];
  logic [7:0] r_mask      [SLOTS];
  logic [7:0] w_mask_nxt  [SLOTS];
  logic [3:0] r_spawn_cnt, w_spawn_cnt_nxt;
  logic [2:0] r_pipe_count, w_count_nxt;
  logic       r_score, w_score_nxt;
  logic       r_drop, w_drop_nxt;
  logic       w_run_tick;
  logic       w_placed;

  logic [2:0] w_gap_top;
  logic [3:0] w_gap_sz;
  logic [7:0] w_gap_mask;

  gap_legalize #(
    .MIN_GAP (MIN_GAP)
  ) u_gap_legalize (
    .gap_height (gap_height),
    .gap_size   (gap_size),
    .top        (w_gap_top),
    .sz         (w_gap_sz),
    .mask       (w_gap_mask)
  );

  // ---------------------------------------------------------------- FSM ----
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (enable)  w_state_nxt = ST_RUN;
        ST_RUN:   if (!enable) w_state_nxt = ST_PAUSE;
        ST_PAUSE: if (enable)  w_state_nxt = ST_RUN;
        default:               w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    state      = r_state;
    w_run_tick = (r_state == ST_RUN) && tick;
  end

  // ----------------------------------------------------------- datapath ----
  always_comb begin
    w_slots_nxt     = r_slots;
    w_mask_nxt      = r_mask;
    w_spawn_cnt_nxt = r_spawn_cnt;
    w_score_nxt     = 1'b0;
    w_drop_nxt      = 1'b0;
    w_placed        = 1'b0;
    w_count_nxt     = '0;

    if (clear) begin
      for (int i = 0; i < SLOTS; i++) begin
        w_slots_nxt[i] = '0;
        w_mask_nxt[i]  = '0;
      end
      w_spawn_cnt_nxt = '0;
    end else if (w_run_tick) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (r_slots[i].valid) begin
          if (r_slots[i].x == BIRD_X) w_score_nxt = 1'b1;
          if (r_slots[i].x == 4'd0) w_slots_nxt[i].valid = 1'b0;
          else                      w_slots_nxt[i].x     = r_slots[i].x - 4'd1;
        end
      end

      if (r_spawn_cnt == 4'd0) begin
        w_spawn_cnt_nxt = SPAWN_RELOAD;
        // Free-slot search sees slots retired on this same tick.
        for (int i = 0; i < SLOTS; i++) begin
          if (!w_placed && !w_slots_nxt[i].valid) begin
            w_slots_nxt[i] = '{valid: 1'b1, x: LAST_X, top: w_gap_top, sz: w_gap_sz};
            w_mask_nxt[i]  = w_gap_mask;
            w_placed       = 1'b1;
          end
        end
        w_drop_nxt = !w_placed;
      end else begin
        w_spawn_cnt_nxt = r_spawn_cnt - 4'd1;
      end
    end

    for (int i = 0; i < SLOTS; i++) begin
      w_count_nxt = w_count_nxt + 3'(w_slots_nxt[i].valid);
    end
  end

  // NOTE: the slot table is a handful of flops, not a RAM, so every entry is
  // reset; a reset mid-run must leave no stale pipe visible.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_slots[i] <= '0;
        r_mask[i]  <= '0;
      end
      r_spawn_cnt  <= '0;
      r_pipe_count <= '0;
      r_score      <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_slots      <= w_slots_nxt;
      r_mask       <= w_mask_nxt;
      r_spawn_cnt  <= w_spawn_cnt_nxt;
      r_pipe_count <= w_count_nxt;
      r_score      <= w_score_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

  assign pipe_count  = r_pipe_count;
  assign score_pulse = r_score;
  assign spawn_drop  = r_drop;

  // Display lookup: OR of the wall masks of every pipe in the scanned column.
  always_comb begin
    rd_pixels = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (r_slots[i].valid && (r_slots[i].x == rd_col)) rd_pixels = rd_pixels | r_mask[i];
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: drives two schedulers (SPACING=5 and SPACING=2) with the
// same stimulus and compares both against a table-level reference model.
module tb_pipe_scheduler;

  localparam int NDUT   = 2;
  localparam int SLOTS  = 4;
  localparam int NCOLS  = 16;
  localparam int BIRD   = 2;
  localparam int MINGAP = 2;

  int spacing [NDUT] = '{5, 2};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] gap_height = '0;
  logic [2:0] gap_size = '0;
  logic [3:0] rd_col = '0;

  logic [7:0] pix0, pix1;
  logic [2:0] cnt0, cnt1;
  logic       score0, score1, drop0, drop1;
  logic [1:0] state0, state1;

  int n_checks = 0;
  int n_errors = 0;

  pipe_scheduler #(.SPACING(5)) dut5 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .tick(tick),
    .gap_height(gap_height), .gap_size(gap_size), .rd_col(rd_col),
    .rd_pixels(pix0), .pipe_count(cnt0), .score_pulse(score0),
    .spawn_drop(drop0), .state(state0)
  );

  pipe_scheduler #(.SPACING(2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .tick(tick),
    .gap_height(gap_height), .gap_size(gap_size), .rd_col(rd_col),
    .rd_pixels(pix1), .pipe_count(cnt1), .score_pulse(score1),
    .spawn_drop(drop1), .state(state1)
  );

  always #20 clock = ~clock;

  function automatic logic [7:0] obs_pix(int m);   return (m == 0) ? pix0   : pix1;   endfunction
  function automatic logic [2:0] obs_cnt(int m);   return (m == 0) ? cnt0   : cnt1;   endfunction
  function automatic logic       obs_score(int m); return (m == 0) ? score0 : score1; endfunction
  function automatic logic       obs_drop(int m);  return (m == 0) ? drop0  : drop1;  endfunction
  function automatic logic [1:0] obs_state(int m); return (m == 0) ? state0 : state1; endfunction

  // ------------------------------------------------------ reference model --
  int m_state;
  bit m_valid [NDUT][SLOTS];
  int m_x     [NDUT][SLOTS];
  int m_top   [NDUT][SLOTS];
  int m_sz    [NDUT][SLOTS];
  int m_cnt   [NDUT];
  bit m_score [NDUT];
  bit m_drop  [NDUT];

  task automatic model_flush();
    for (int m = 0; m < NDUT; m++) begin
      for (int s = 0; s < SLOTS; s++) begin
        m_valid[m][s] = 0; m_x[m][s] = 0; m_top[m][s] = 0; m_sz[m][s] = 0;
      end
      m_cnt[m] = 0;
    end
  endtask

  task automatic model_edge();
    int sz, top;
    bit placed;
    for (int m = 0; m < NDUT; m++) begin m_score[m] = 0; m_drop[m] = 0; end
    if (!reset) begin
      m_state = 0;
      model_flush();
      return;
    end
    if (clear) begin
      m_state = 0;
      model_flush();
      return;
    end
    if (m_state == 1 && tick) begin
      sz  = (int'(gap_size) < MINGAP) ? MINGAP : int'(gap_size);
      top = (int'(gap_height) + sz > 8) ? 8 - sz : int'(gap_height);
      for (int m = 0; m < NDUT; m++) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (m_valid[m][s]) begin
            if (m_x[m][s] == BIRD) m_score[m] = 1;
            if (m_x[m][s] == 0) m_valid[m][s] = 0;
            else m_x[m][s]--;
          end
        end
        if (m_cnt[m] == 0) begin
          m_cnt[m] = spacing[m] - 1;
          placed = 0;
          for (int s = 0; s < SLOTS; s++) begin
            if (!placed && !m_valid[m][s]) begin
              m_valid[m][s] = 1; m_x[m][s] = NCOLS - 1;
              m_top[m][s] = top; m_sz[m][s] = sz;
              placed = 1;
            end
          end
          m_drop[m] = !placed;
        end else begin
          m_cnt[m]--;
        end
      end
    end
    case (m_state)
      0: if (enable)  m_state = 1;
      1: if (!enable) m_state = 2;
      2: if (enable)  m_state = 1;
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [7:0] exp_pix(int m, int col);
    logic [7:0] p = 8'h00;
    for (int s = 0; s < SLOTS; s++) begin
      if (m_valid[m][s] && m_x[m][s] == col) begin
        for (int r = 0; r < 8; r++) begin
          if (r < m_top[m][s] || r >= m_top[m][s] + m_sz[m][s]) p[r] = 1'b1;
        end
      end
    end
    return p;
  endfunction

  function automatic int exp_cnt(int m);
    int c = 0;
    for (int s = 0; s < SLOTS; s++) c += int'(m_valid[m][s]);
    return c;
  endfunction

  // One rising edge, model updated with the inputs sampled there, then #1.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  task automatic go_run();
    clear = 1'b1; enable = 1'b1;
    cycle();
    clear = 1'b0;
    cycle();
  endtask

  // --------------------------------------------------------------- tests --
  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; tick = 1'b1; clear = 1'b0;
    repeat (3) cycle();
    tick = 1'b0;
    for (int m = 0; m < NDUT; m++) begin
      n_checks++;
      if (obs_state(m) !== 2'd0) begin n_errors++; $display("FAIL reset_state dut%0d: got %0d want 0", m, obs_state(m)); end
      n_checks++;
      if (obs_cnt(m) !== 3'd0) begin n_errors++; $display("FAIL reset_count dut%0d: got %0d want 0", m, obs_cnt(m)); end
      n_checks++;
      if ({obs_score(m), obs_drop(m)} !== 2'b00) begin n_errors++; $display("FAIL reset_pulses dut%0d: got %b want 00", m, {obs_score(m), obs_drop(m)}); end
    end
    for (int c = 0; c < NCOLS; c++) begin
      rd_col = 4'(c); #1;
      for (int m = 0; m < NDUT; m++) begin
        n_checks++;
        if (obs_pix(m) !== 8'h00) begin n_errors++; $display("FAIL reset_pixels dut%0d col%0d: got %h want 00", m, c, obs_pix(m)); end
      end
    end
  endtask

  task automatic test_first_spawn();
    reset = 1'b1; enable = 1'b1; gap_height = 3'd1; gap_size = 3'd3;
    cycle();
    for (int m = 0; m < NDUT; m++) begin
      n_checks++;
      if (obs_state(m) !== 2'd1) begin n_errors++; $display("FAIL idle_to_run dut%0d: got %0d want 1", m, obs_state(m)); end
    end
    do_tick();
    gap_height = 3'd5;
    rd_col = 4'd15; #1;
    for (int m = 0; m < NDUT; m++) begin
      n_checks++;
      if (obs_pix(m) !== 8'b1111_0001) begin n_errors++; $display("FAIL first_spawn_pix dut%0d: got %b want 11110001", m, obs_pix(m)); end
      n_checks++;
      if (obs_cnt(m) !== 3'd1) begin n_errors++; $display("FAIL first_spawn_count dut%0d: got %0d want 1", m, obs_cnt(m)); end
    end
  endtask

  task automatic test_gap_clamp();
    go_run();
    gap_height = 3'd6; gap_size = 3'd0;
    do_tick();
    rd_col = 4'd15; #1;
    for (int m = 0; m < NDUT; m++) begin
      n_checks++;
      if (obs_pix(m) !== 8'b0011_1111) begin n_errors++; $display("FAIL gap_clamp dut%0d: got %b want 00111111", m, obs_pix(m)); end
    end
    // Gap inputs changing between spawns must not alter the stored pipe.
    gap_height = 3'd0; gap_size = 3'd7;
    cycle();
    gap_height = 3'd3; gap_size = 3'd5;
    do_tick();
    for (int m = 0; m < NDUT; m++) begin
      rd_col = 4'd14; #1;
      n_checks++;
      if (obs_pix(m) !== 8'b0011_1111) begin n_errors++; $display("FAIL gap_hold dut%0d: got %b want 00111111", m, obs_pix(m)); end
      rd_col = 4'd15; #1;
      n_checks++;
      if (obs_pix(m) !== 8'h00) begin n_errors++; $display("FAIL no_spawn_col15 dut%0d: got %h want 00", m, obs_pix(m)); end
    end
  endtask

  task automatic test_table_full();
    go_run();
    for (int t = 1; t <= 9; t++) begin
      gap_height = 3'($urandom_range(7)); gap_size = 3'($urandom_range(7));
      do_tick();
      n_checks++;
      if (obs_drop(1) !== (t == 9)) begin n_errors++; $display("FAIL drop_tick%0d: got %b want %b", t, obs_drop(1), (t == 9)); end
      n_checks++;
      if (int'(obs_cnt(1)) != (((t + 1) / 2 > 4) ? 4 : (t + 1) / 2)) begin
        n_errors++; $display("FAIL full_count_tick%0d: got %0d want %0d", t, obs_cnt(1), ((t + 1) / 2 > 4) ? 4 : (t + 1) / 2);
      end
      n_checks++;
      if (obs_drop(0) !== m_drop[0]) begin n_errors++; $display("FAIL drop5_tick%0d: got %b want %b", t, obs_drop(0), m_drop[0]); end
    end
    cycle();
    n_checks++;
    if (obs_drop(1) !== 1'b0) begin n_errors++; $display("FAIL drop_one_cycle: got %b want 0", obs_drop(1)); end
  endtask

  task automatic test_score();
    int n_score = 0;
    int score_at = -1;
    go_run();
    for (int t = 1; t <= 17; t++) begin
      gap_height = 3'($urandom_range(7)); gap_size = 3'($urandom_range(7));
      do_tick();
      if (obs_score(0) === 1'b1) begin n_score++; score_at = t; end
      for (int m = 0; m < NDUT; m++) begin
        n_checks++;
        if (obs_score(m) !== m_score[m]) begin n_errors++; $display("FAIL score_tick%0d dut%0d: got %b want %b", t, m, obs_score(m), m_score[m]); end
      end
      if (t == 16) begin
        rd_col = 4'd0; #1;
        n_checks++;
        if (obs_pix(0) !== exp_pix(0, 0) || obs_pix(0) === 8'h00) begin
          n_errors++; $display("FAIL pipe_at_col0: got %h want %h", obs_pix(0), exp_pix(0, 0));
        end
      end
    end
    n_checks++;
    if (n_score != 1 || score_at != 15) begin n_errors++; $display("FAIL score_once: got %0d pulses at tick %0d want 1 at 15", n_score, score_at); end
    rd_col = 4'd0; #1;
    n_checks++;
    if (obs_pix(0) !== 8'h00) begin n_errors++; $display("FAIL retired_col0: got %h want 00", obs_pix(0)); end
    n_checks++;
    if (obs_cnt(0) !== 3'd3) begin n_errors++; $display("FAIL count_after_retire: got %0d want 3", obs_cnt(0)); end
  endtask

  task automatic test_pause();
    logic [7:0] snap [NDUT][NCOLS];
    go_run();
    repeat (4) begin
      gap_height = 3'($urandom_range(7)); gap_size = 3'($urandom_range(7));
      do_tick();
    end
    enable = 1'b0;
    cycle();
    for (int m = 0; m < NDUT; m++)
      for (int c = 0; c < NCOLS; c++) snap[m][c] = exp_pix(m, c);
    repeat (3) begin
      do_tick();
      for (int c = 0; c < NCOLS; c++) begin
        rd_col = 4'(c); #1;
        for (int m = 0; m < NDUT; m++) begin
          n_checks++;
          if (obs_pix(m) !== snap[m][c]) begin n_errors++; $display("FAIL pause_frozen dut%0d col%0d: got %h want %h", m, c, obs_pix(m), snap[m][c]); end
        end
      end
      for (int m = 0; m < NDUT; m++) begin
        n_checks++;
        if (obs_state(m) !== 2'd2) begin n_errors++; $display("FAIL pause_state dut%0d: got %0d want 2", m, obs_state(m)); end
      end
    end
    enable = 1'b1;
    cycle();
    for (int m = 0; m < NDUT; m++) begin
      n_checks++;
      if (obs_state(m) !== 2'd1) begin n_errors++; $display("FAIL resume_state dut%0d: got %0d want 1", m, obs_state(m)); end
    end
    do_tick();
    for (int c = 0; c < NCOLS - 2; c++) begin
      rd_col = 4'(c); #1;
      for (int m = 0; m < NDUT; m++) begin
        n_checks++;
        if (obs_pix(m) !== snap[m][c+1]) begin n_errors++; $display("FAIL resume_shift dut%0d col%0d: got %h want %h", m, c, obs_pix(m), snap[m][c+1]); end
      end
    end
  endtask

  task automatic test_clear_reset();
    for (int pass = 0; pass < 2; pass++) begin
      go_run();
      repeat (8) begin
        gap_height = 3'($urandom_range(7)); gap_size = 3'($urandom_range(7));
        do_tick();
      end
      // Ninth tick would spawn into a full table on the SPACING=2 instance.
      tick = 1'b1;
      if (pass == 0) clear = 1'b1; else reset = 1'b0;
      cycle();
      tick = 1'b0; clear = 1'b0; reset = 1'b1;
      for (int m = 0; m < NDUT; m++) begin
        n_checks++;
        if (obs_state(m) !== 2'd0) begin n_errors++; $display("FAIL flush%0d_state dut%0d: got %0d want 0", pass, m, obs_state(m)); end
        n_checks++;
        if (obs_cnt(m) !== 3'd0) begin n_errors++; $display("FAIL flush%0d_count dut%0d: got %0d want 0", pass, m, obs_cnt(m)); end
        n_checks++;
        if ({obs_score(m), obs_drop(m)} !== 2'b00) begin n_errors++; $display("FAIL flush%0d_pulses dut%0d: got %b want 00", pass, m, {obs_score(m), obs_drop(m)}); end
      end
      for (int c = 0; c < NCOLS; c++) begin
        rd_col = 4'(c); #1;
        for (int m = 0; m < NDUT; m++) begin
          n_checks++;
          if (obs_pix(m) !== 8'h00) begin n_errors++; $display("FAIL flush%0d_pix dut%0d col%0d: got %h want 00", pass, m, c, obs_pix(m)); end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable     = ($urandom_range(7) != 0);
      tick       = $urandom_range(1);
      clear      = ($urandom_range(63) == 0);
      reset      = ($urandom_range(127) != 0);
      gap_height = 3'($urandom_range(7));
      gap_size   = 3'($urandom_range(7));
      cycle();
      rd_col = 4'($urandom_range(15)); #1;
      for (int m = 0; m < NDUT; m++) begin
        n_checks++;
        if (obs_state(m) !== 2'(m_state) || int'(obs_cnt(m)) != exp_cnt(m) ||
            obs_score(m) !== m_score[m] || obs_drop(m) !== m_drop[m]) begin
          n_errors++;
          $display("FAIL rand%0d_status dut%0d: got st%0d n%0d s%b d%b want st%0d n%0d s%b d%b", i, m,
                   obs_state(m), obs_cnt(m), obs_score(m), obs_drop(m), m_state, exp_cnt(m), m_score[m], m_drop[m]);
        end
        n_checks++;
        if (obs_pix(m) !== exp_pix(m, int'(rd_col))) begin
          n_errors++; $display("FAIL rand%0d_pix dut%0d col%0d: got %h want %h", i, m, rd_col, obs_pix(m), exp_pix(m, int'(rd_col)));
        end
      end
    end
    tick = 1'b0; clear = 1'b0; reset = 1'b1;
  endtask

  initial begin
    m_state = 0;
    model_flush();
    test_reset();
    test_first_spawn();
    test_gap_clamp();
    test_table_full();
    test_score();
    test_pause();
    test_clear_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 Parameters SHALL be: COLS, default 16, playfield columns; SLOTS, default 4, pipe table entries; SPACING, default 5, ticks between spawns, legal range 2..15; BIRD_COL, default 2, bird column, legal range 1..COLS-1; MIN_GAP, default 2, minimum open rows.
REQ-002 Ports SHALL be:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low; asserted when 0.
- enable  in  1  run request; low pauses.
- clear  in  1  synchronous table flush.
- tick  in  1  one-cycle scroll strobe.
- gap_height  in  3  gap top row from the gap generator.
- gap_size  in  3  raw gap size from the gap generator.
- rd_col  in  4  display scan column.
- rd_pixels  out  8  wall bits for rd_col; bit r=1 means row r is solid.
- pipe_count  out  3  number of valid slots.
- score_pulse  out  1  a pipe passed the bird.
- spawn_drop  out  1  a spawn was lost because the table was full.
- state  out  2  FSM state.

Function
REQ-003 The FSM SHALL have three states, encoded IDLE=0, RUN=1, PAUSE=2:
- IDLE->RUN when enable=1.
- RUN->PAUSE when enable=0.
- PAUSE->RUN when enable=1.
- Any state->IDLE when clear=1; clear has priority over enable and tick.
REQ-004 Entering IDLE SHALL invalidate all slots and load spawn_cnt=0, so that the first RUN tick spawns.
REQ-005 tick SHALL be acted on only in RUN, and only when sampled on a rising edge. Results SHALL be visible in the following cycle. tick in IDLE or PAUSE SHALL be ignored.
REQ-006 On a RUN tick, every valid slot SHALL have x decremented by 1. A valid slot with x=0 SHALL be retired (valid cleared) instead.
REQ-007 On a RUN tick with spawn_cnt=0:
- Write the lowest-index invalid slot, evaluated after same-tick retirement, with valid=1, x=COLS-1, and the legalized gap.
- Reload spawn_cnt=SPACING-1.
REQ-008 On a RUN tick with spawn_cnt!=0, spawn_cnt SHALL decrement by 1.
REQ-009 If a spawn finds no free slot, no slot is written, spawn_cnt still reloads, and spawn_drop SHALL pulse for one cycle.
REQ-010 Gap legalization SHALL be:
- sz = max(gap_size, MIN_GAP).
- top = gap_height, except when gap_height+sz>8, in which case top = 8-sz.
- Open rows are top..top+sz-1; all other rows are solid.
- The arithmetic SHALL be 4-bit so that no wrap occurs.
REQ-011 score_pulse SHALL be a one-cycle pulse in the cycle after any RUN tick that moves a valid slot from x=BIRD_COL to BIRD_COL-1.
REQ-012 rd_pixels SHALL be combinational. It is the OR over valid slots with x==rd_col of each slot's solid-row mask, and 8'h00 if there is no match.
REQ-013 pipe_count SHALL be the registered popcount of the valid bits.
REQ-014 Gap inputs SHALL be sampled only on the spawn edge. Changes on other cycles SHALL have no effect.

Reset
REQ-015 While reset=0 on a rising edge:
- state=IDLE.
- All slots invalid, with x=0, top=0, sz=0.
- spawn_cnt=0, pipe_count=0, score_pulse=0, spawn_drop=0.
REQ-016 Reset SHALL override clear, enable and tick.
REQ-017 A reset mid-RUN SHALL discard all pipes with no score_pulse or spawn_drop. The block then resumes per REQ-003 once reset=1.

Structure
REQ-018 The following SHALL live in shared package flappy_pkg:
- Constants ROWS=8 and COLS.
- The state enum.
- Packed struct pipe_slot_t with fields valid, x[3:0], top[2:0], sz[3:0].
REQ-019 Legalization and solid-mask generation SHALL be a combinational sub-module gap_legalize, which takes gap_height and gap_size and produces top, sz and mask[7:0].
REQ-020 pipe_scheduler SHALL NOT contain an LFSR. It consumes the existing gap generator's outputs.

Verification
REQ-021 Reset then enable=1, gap_height=1, gap_size=3, one tick -> slot0 valid with x=15; rd_col=15 gives rd_pixels=8'b1111_0001; pipe_count=1.
REQ-022 gap_height=6, gap_size=0 at the spawn tick -> sz=2, top=6; rd_pixels=8'b0011_1111.
REQ-023 SPACING=2, SLOTS=4, COLS=16, 9 ticks -> spawns occur on ticks 1, 3, 5 and 7 and fill four slots; the tick-9 spawn pulses spawn_drop; pipe_count stays 4.
REQ-024 Single pipe spawned at x=15, then 13 further ticks -> score_pulse exactly once, in the cycle after the tick that moves x from 2 to 1; the pipe retires on the 16th tick after spawn.
REQ-025 enable=0 mid-run, 3 ticks, then enable=1 -> no x change during PAUSE and state=2; after resume, motion continues from the frozen x.
REQ-026 clear=1 concurrent with tick, and separately reset=0 mid-run -> next cycle state=IDLE, pipe_count=0, rd_pixels=0 for all columns, and no pulses.
